// File: rtl/fpnew_result_reorder_if.sv
// Status flags type and the bundled requester/consumer bus of the result
// reorder buffer.
//
// fpnew_pkg : status_t exception flags (NV, DZ, OF, UF, NX).
// fpnew_result_reorder_if : issue, result, output and flush signals.
//   slave  modport : reorder buffer view (issue/res/out_ready/flush inputs).
//   master modport : environment view (drives the slave inputs).
package fpnew_pkg;
    typedef struct packed {
        logic nv;  // invalid operation
        logic dz;  // divide by zero
        logic of;  // overflow
        logic uf;  // underflow
        logic nx;  // inexact
    } status_t;
endpackage

interface fpnew_result_reorder_if #(
    parameter int unsigned Width   = 32,
    parameter int unsigned IdWidth = 2,
    parameter type         TagType = logic
);
    logic                 flush_i;
    logic                 issue_valid_i;
    logic                 issue_ready_o;
    TagType               issue_tag_i;
    logic [IdWidth-1:0]   issue_id_o;
    logic                 res_valid_i;
    logic                 res_ready_o;
    logic [IdWidth-1:0]   res_id_i;
    logic [Width-1:0]     res_result_i;
    fpnew_pkg::status_t   res_status_i;
    logic                 res_ext_bit_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [Width-1:0]     out_result_o;
    fpnew_pkg::status_t   out_status_o;
    logic                 out_ext_bit_o;
    TagType               out_tag_o;
    logic                 busy_o;

    modport slave (
        input  flush_i, issue_valid_i, issue_tag_i, res_valid_i, res_id_i,
               res_result_i, res_status_i, res_ext_bit_i, out_ready_i,
        output issue_ready_o, issue_id_o, res_ready_o, out_valid_o,
               out_result_o, out_status_o, out_ext_bit_o, out_tag_o, busy_o
    );

    modport master (
        output flush_i, issue_valid_i, issue_tag_i, res_valid_i, res_id_i,
               res_result_i, res_status_i, res_ext_bit_i, out_ready_i,
        input  issue_ready_o, issue_id_o, res_ready_o, out_valid_o,
               out_result_o, out_status_o, out_ext_bit_o, out_tag_o, busy_o
    );
endinterface

// File: rtl/fpnew_result_reorder.sv
// Requester-side reorder buffer for an FPnew opgroup. Hands out a transaction
// ID per issued operation, accepts results tagged with that ID in any order,
// and releases them to the core strictly in issue order with the user tag.
//
// Ports:
//   clk_i  : clock, all state changes on the rising edge.
//   rst_ni : asynchronous active-low reset.
//   bus    : slave view of fpnew_result_reorder_if (issue / result / output
//            handshakes, flush, busy).
module fpnew_result_reorder #(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    fpnew_result_reorder_if.slave  bus
);
    localparam int unsigned IdWidth = $clog2(Depth);
    localparam logic [IdWidth:0]   CntFull = Depth[IdWidth:0];
    localparam logic [IdWidth:0]   CntOne  = 1;
    localparam logic [IdWidth-1:0] PtrOne  = 1;

    logic [IdWidth-1:0]                head_q, head_d, tail_q, tail_d;
    logic [IdWidth:0]                  count_q, count_d;
    logic [Depth-1:0]                  alloc_q, alloc_d, done_q, done_d;
    TagType                            tag_q    [Depth];
    TagType                            tag_d    [Depth];
    logic [Depth-1:0][Width-1:0]       result_q, result_d;
    fpnew_pkg::status_t [Depth-1:0]    status_q, status_d;
    logic [Depth-1:0]                  ext_q, ext_d;

    logic issue_fire, res_accept, retire;

    // Ready is a pure function of registered occupancy, so a retire while
    // full cannot open the issue port in the same cycle.
    assign bus.issue_ready_o = (count_q != CntFull);
    assign bus.issue_id_o    = tail_q;
    assign bus.res_ready_o   = 1'b1;
    assign bus.busy_o        = (count_q != '0);

    assign bus.out_valid_o   = alloc_q[head_q] & done_q[head_q];
    assign bus.out_result_o  = result_q[head_q];
    assign bus.out_status_o  = status_q[head_q];
    assign bus.out_ext_bit_o = ext_q[head_q];
    assign bus.out_tag_o     = tag_q[head_q];

    assign issue_fire = bus.issue_valid_i & bus.issue_ready_o;
    // alloc is registered, so a result for an entry issued this very cycle
    // sees alloc=0 and is dropped.
    assign res_accept = bus.res_valid_i & alloc_q[bus.res_id_i] & ~done_q[bus.res_id_i];
    assign retire     = bus.out_valid_o & bus.out_ready_i;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        alloc_d  = alloc_q;
        done_d   = done_q;
        tag_d    = tag_q;
        result_d = result_q;
        status_d = status_q;
        ext_d    = ext_q;

        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            alloc_d = '0;
            done_d  = '0;
        end else begin
            // Issue, result and retire always target distinct entries: issue
            // hits a free slot, result an allocated not-done slot, retire a
            // done slot.
            if (issue_fire) begin
                alloc_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tag_d[tail_q]   = bus.issue_tag_i;
                tail_d          = tail_q + PtrOne;
            end
            if (res_accept) begin
                done_d[bus.res_id_i]   = 1'b1;
                result_d[bus.res_id_i] = bus.res_result_i;
                status_d[bus.res_id_i] = bus.res_status_i;
                ext_d[bus.res_id_i]    = bus.res_ext_bit_i;
            end
            if (retire) begin
                alloc_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + PtrOne;
            end
            unique case ({issue_fire, retire})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            alloc_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            status_q <= '0;
            ext_q    <= '0;
            for (int i = 0; i < Depth; i++) tag_q[i] <= TagType'(0);
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            alloc_q  <= alloc_d;
            done_q   <= done_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            status_q <= status_d;
            ext_q    <= ext_d;
        end
    end

`ifndef SYNTHESIS
    // Flags results that get dropped: unallocated ID, duplicate, or a result
    // racing its own issue. Results during flush are discarded on purpose.
    always @(posedge clk_i) begin
        if (rst_ni && bus.res_valid_i && !bus.flush_i) begin
            assert (res_accept)
            else $warning("reorder: dropped result for id %0d", bus.res_id_i);
        end
    end
`endif
endmodule

// File: tb/tb_fpnew_result_reorder.sv
module tb_fpnew_result_reorder;
    typedef logic [7:0] tag_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fpnew_result_reorder_if #(.Width(32), .IdWidth(2), .TagType(tag_t)) bus ();

    fpnew_result_reorder #(.Width(32), .Depth(4), .TagType(tag_t)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_out_valid"},   bus.out_valid_o,   0);
        chk({pfx, "_issue_ready"}, bus.issue_ready_o, 1);
        chk({pfx, "_issue_id"},    bus.issue_id_o,    0);
        chk({pfx, "_busy"},        bus.busy_o,        0);
        chk({pfx, "_out_result"},  bus.out_result_o,  0);
        chk({pfx, "_out_status"},  bus.out_status_o,  0);
        chk({pfx, "_out_ext"},     bus.out_ext_bit_o, 0);
        chk({pfx, "_out_tag"},     bus.out_tag_o,     0);
        chk({pfx, "_res_ready"},   bus.res_ready_o,   1);
    endtask

    task automatic issue(input tag_t t);
        bus.issue_valid_i = 1'b1;
        bus.issue_tag_i   = t;
        tick();
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic set_res(input logic v, input logic [1:0] id, input logic [31:0] d);
        bus.res_valid_i  = v;
        bus.res_id_i     = id;
        bus.res_result_i = d;
    endtask

    initial begin
        bus.flush_i       = 1'b0;
        bus.issue_valid_i = 1'b0;
        bus.issue_tag_i   = '0;
        bus.res_valid_i   = 1'b0;
        bus.res_id_i      = '0;
        bus.res_result_i  = '0;
        bus.res_status_i  = '0;
        bus.res_ext_bit_i = 1'b0;
        bus.out_ready_i   = 1'b0;

        #1 rst_n = 1'b0;
        #2 chk_reset_vals("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // In-order: tags A1,B2,C3 on IDs 0,1,2.
        issue(8'hA1);
        issue(8'hB2);
        issue(8'hC3);
        chk("io_busy", bus.busy_o, 1);
        chk("io_tail", bus.issue_id_o, 3);
        chk("io_no_out", bus.out_valid_o, 0);
        set_res(1, 0, 32'd100);
        tick();
        chk("io_v0", bus.out_valid_o, 1);
        chk("io_tag0", bus.out_tag_o, 8'hA1);
        chk("io_res0", bus.out_result_o, 100);
        bus.out_ready_i = 1'b1;
        set_res(1, 1, 32'd101);
        tick();
        chk("io_v1", bus.out_valid_o, 1);
        chk("io_tag1", bus.out_tag_o, 8'hB2);
        chk("io_res1", bus.out_result_o, 101);
        set_res(1, 2, 32'd102);
        tick();
        chk("io_tag2", bus.out_tag_o, 8'hC3);
        chk("io_res2", bus.out_result_o, 102);
        set_res(0, 0, 0);
        tick();
        bus.out_ready_i = 1'b0;
        chk("io_drained_v", bus.out_valid_o, 0);
        chk("io_drained_busy", bus.busy_o, 0);
        chk("io_drained_id", bus.issue_id_o, 3);

        // Flush on empty buffer rewinds pointers to 0.
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        chk("fl0_id", bus.issue_id_o, 0);

        // Out-of-order: IDs 0..3, results returned 3,1,2,0.
        issue(8'h10);
        issue(8'h11);
        issue(8'h12);
        issue(8'h13);
        chk("full_ready", bus.issue_ready_o, 0);
        chk("full_busy", bus.busy_o, 1);
        set_res(1, 3, 32'hC0DE0203);
        tick();
        chk("ooo_wait3", bus.out_valid_o, 0);
        set_res(1, 1, 32'hC0DE0201);
        tick();
        chk("ooo_wait1", bus.out_valid_o, 0);
        set_res(1, 2, 32'hC0DE0202);
        tick();
        chk("ooo_wait2", bus.out_valid_o, 0);
        set_res(1, 0, 32'hC0DE0200);
        tick();
        set_res(0, 0, 0);
        chk("ooo_v0", bus.out_valid_o, 1);
        chk("ooo_tag0", bus.out_tag_o, 8'h10);
        chk("ooo_res0", bus.out_result_o, 32'hC0DE0200);
        // Hold while full with consumer stalled.
        tick();
        tick();
        chk("hold_v", bus.out_valid_o, 1);
        chk("hold_tag", bus.out_tag_o, 8'h10);
        chk("hold_res", bus.out_result_o, 32'hC0DE0200);
        chk("hold_ready", bus.issue_ready_o, 0);
        bus.out_ready_i = 1'b1;
        tick();
        chk("ooo_tag1", bus.out_tag_o, 8'h11);
        chk("ooo_res1", bus.out_result_o, 32'hC0DE0201);
        tick();
        chk("ooo_tag2", bus.out_tag_o, 8'h12);
        chk("ooo_res2", bus.out_result_o, 32'hC0DE0202);
        tick();
        chk("ooo_tag3", bus.out_tag_o, 8'h13);
        chk("ooo_res3", bus.out_result_o, 32'hC0DE0203);
        tick();
        bus.out_ready_i = 1'b0;
        chk("ooo_empty_v", bus.out_valid_o, 0);
        chk("ooo_empty_busy", bus.busy_o, 0);
        chk("ooo_wrap_id", bus.issue_id_o, 0);

        // Simultaneous retire and issue while full.
        issue(8'h20);
        issue(8'h21);
        issue(8'h22);
        issue(8'h23);
        set_res(1, 0, 32'd300);
        tick();
        set_res(0, 0, 0);
        bus.out_ready_i   = 1'b1;
        bus.issue_valid_i = 1'b1;
        bus.issue_tag_i   = 8'h24;
        chk("sim_ready_blocked", bus.issue_ready_o, 0);
        chk("sim_v", bus.out_valid_o, 1);
        chk("sim_tag", bus.out_tag_o, 8'h20);
        tick();
        bus.out_ready_i = 1'b0;
        chk("sim_ready_next", bus.issue_ready_o, 1);
        chk("sim_id_next", bus.issue_id_o, 0);
        tick();
        bus.issue_valid_i = 1'b0;
        chk("sim_full_again", bus.issue_ready_o, 0);
        chk("sim_tail", bus.issue_id_o, 1);

        // Illegal results: duplicate on a done entry, then unallocated ID.
        set_res(1, 1, 32'd301);
        tick();
        set_res(1, 1, 32'd999);
        tick();
        set_res(0, 0, 0);
        chk("dup_v", bus.out_valid_o, 1);
        chk("dup_tag", bus.out_tag_o, 8'h21);
        chk("dup_res", bus.out_result_o, 301);
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        set_res(1, 1, 32'd777);
        tick();
        set_res(0, 0, 0);
        chk("unalloc_v", bus.out_valid_o, 0);
        chk("unalloc_ready", bus.issue_ready_o, 1);
        chk("unalloc_id", bus.issue_id_o, 1);

        // Flush with 3 in flight (IDs 2,3,0) and a concurrent result.
        bus.flush_i = 1'b1;
        set_res(1, 2, 32'd888);
        tick();
        bus.flush_i = 1'b0;
        set_res(0, 0, 0);
        chk("flush_busy", bus.busy_o, 0);
        chk("flush_v", bus.out_valid_o, 0);
        chk("flush_id", bus.issue_id_o, 0);
        chk("flush_ready", bus.issue_ready_o, 1);
        set_res(1, 2, 32'd889);
        tick();
        set_res(1, 0, 32'd890);
        tick();
        set_res(0, 0, 0);
        chk("late_v", bus.out_valid_o, 0);
        chk("late_busy", bus.busy_o, 0);

        // Fresh entry after flush, with status and ext bit.
        issue(8'h30);
        bus.res_status_i  = 5'b10101;
        bus.res_ext_bit_i = 1'b1;
        set_res(1, 0, 32'h00001234);
        tick();
        set_res(0, 0, 0);
        bus.res_status_i  = '0;
        bus.res_ext_bit_i = 1'b0;
        chk("post_v", bus.out_valid_o, 1);
        chk("post_tag", bus.out_tag_o, 8'h30);
        chk("post_res", bus.out_result_o, 32'h00001234);
        chk("post_status", bus.out_status_o, 5'b10101);
        chk("post_ext", bus.out_ext_bit_o, 1);

        // Asynchronous reset mid-operation, away from the clock edge.
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
